// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Round-robin arbiter that shares one 3-bit signed ALU (AND/OR/ADD/SUB with a
//   signed overflow flag) between two requesters. Each transaction steps
//   through IDLE (grant) -> EXEC (compute) -> RESP (hold until accepted).
//
// Configuration macro: ALU_OVF_SATURATE_EN
//   defined   : ADD/SUB overflow clamps the result to +3 or -4
//   undefined : ADD/SUB overflow wraps to the low 3 bits
//
// Ports
//   clk_2      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   [1:0] request valid per requester
//   req_ready  out  [1:0] one-hot grant (combinational, IDLE only)
//   req_a      in   [1:0][2:0] signed operand A per requester
//   req_b      in   [1:0][2:0] signed operand B per requester
//   req_sel    in   [1:0][1:0] op: 00 AND, 01 OR, 10 ADD, 11 SUB
//   rsp_valid  out  response valid
//   rsp_ready  in   response consumed
//   rsp_id     out  requester owning the response
//   rsp_result out  [2:0] signed result
//   rsp_ovf    out  signed overflow flag
//   rsp_seg    out  [7:0] 7-segment pattern of rsp_result
//   busy       out  transaction in flight
//   ops_done   out  [NBITS_CNT-1:0] completed responses, wrapping
module alu_share_arbiter #(
  parameter int NBITS_OPER = 3,
  parameter int NBITS_CNT  = 8
) (
  input  logic                       clk_2,
  input  logic                       reset_n,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][NBITS_OPER-1:0] req_a,
  input  logic [1:0][NBITS_OPER-1:0] req_b,
  input  logic [1:0][1:0]            req_sel,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [NBITS_OPER-1:0]      rsp_result,
  output logic                       rsp_ovf,
  output logic [7:0]                 rsp_seg,
  output logic                       busy,
  output logic [NBITS_CNT-1:0]       ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                  state, next_state;
  logic                    last_grant;
  logic                    grant_q;
  logic [NBITS_OPER-1:0]   a_q, b_q;
  logic [1:0]              sel_q;

  logic                    pick;
  logic [NBITS_OPER:0]     a_ext, b_ext, res_ext;
  logic [NBITS_OPER-1:0]   alu_res;
  logic                    alu_ovf;

  // Segment patterns for the signed range -4..3.
  function automatic logic [7:0] seg_of(input logic [2:0] v);
    case (v)
      3'b000:  seg_of = 8'h3F;
      3'b001:  seg_of = 8'h06;
      3'b010:  seg_of = 8'h5B;
      3'b011:  seg_of = 8'h4F;
      3'b111:  seg_of = 8'h86;
      3'b110:  seg_of = 8'hDB;
      3'b101:  seg_of = 8'hCF;
      default: seg_of = 8'hE6;
    endcase
  endfunction

  // Grant selection: a lone requester wins outright; under contention the
  // requester that was not served last wins.
  always_comb begin
    next_state = state;
    pick       = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    req_ready  = 2'b00;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          next_state = EXEC;
          // Gated by reset_n so the grant is also 0 while held in reset.
          if (reset_n) req_ready = pick ? 2'b10 : 2'b01;
        end
      end
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ALU on sign-extended operands; bits [3] and [2] of the 4-bit result
  // disagree exactly when the true value falls outside -4..3.
  always_comb begin
    a_ext   = {a_q[NBITS_OPER-1], a_q};
    b_ext   = {b_q[NBITS_OPER-1], b_q};
    res_ext = '0;
    alu_ovf = 1'b0;
    case (sel_q)
      2'b00: res_ext = a_ext & b_ext;
      2'b01: res_ext = a_ext | b_ext;
      2'b10: res_ext = a_ext + b_ext;
      default: res_ext = a_ext - b_ext;
    endcase
    if (sel_q[1]) alu_ovf = res_ext[NBITS_OPER] ^ res_ext[NBITS_OPER-1];
`ifdef ALU_OVF_SATURATE_EN
    if (alu_ovf)
      alu_res = res_ext[NBITS_OPER] ? {1'b1, {(NBITS_OPER-1){1'b0}}}
                                    : {1'b0, {(NBITS_OPER-1){1'b1}}};
    else
      alu_res = res_ext[NBITS_OPER-1:0];
`else
    alu_res = res_ext[NBITS_OPER-1:0];
`endif
  end

  // State register, operand capture, response registers and op counter.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= 2'b00;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_ovf    <= 1'b0;
      rsp_seg    <= 8'h00;
      ops_done   <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_q <= pick;
            a_q     <= req_a[pick];
            b_q     <= req_b[pick];
            sel_q   <= req_sel[pick];
          end
        end
        EXEC: begin
          rsp_id     <= grant_q;
          rsp_result <= alu_res;
          rsp_ovf    <= alu_ovf;
          rsp_seg    <= seg_of(alu_res);
        end
        RESP: begin
          if (rsp_ready) begin
            ops_done   <= ops_done + NBITS_CNT'(1);
            last_grant <= grant_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule
